// File: rtl/alu_cmd_queue_pkg.sv
// Shared types and constants for the ALU command front end: opcodes,
// operand/result widths, the queued command layout and the output-register state.
package alu_pkg;

    localparam int OP_W   = 4;
    localparam int OPND_W = 8;
    localparam int RES_W  = 16;
    localparam int CMD_W  = OP_W + 2 * OPND_W;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_MUL = 4'b0010;
    localparam logic [OP_W-1:0] OP_DIV = 4'b0011;
    localparam logic [OP_W-1:0] OP_MOD = 4'b0100;
    localparam logic [OP_W-1:0] OP_AND = 4'b0101;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0110;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0111;
    localparam logic [OP_W-1:0] OP_NOT = 4'b1000;
    localparam logic [OP_W-1:0] OP_SHL = 4'b1001;
    localparam logic [OP_W-1:0] OP_SHR = 4'b1010;
    localparam logic [OP_W-1:0] OP_ROL = 4'b1011;
    localparam logic [OP_W-1:0] OP_ROR = 4'b1100;
    localparam logic [OP_W-1:0] OP_LT  = 4'b1101;
    localparam logic [OP_W-1:0] OP_GT  = 4'b1110;
    localparam logic [OP_W-1:0] OP_EQ  = 4'b1111;

    typedef struct packed {
        logic [OP_W-1:0]   sel;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } alu_cmd_t;

    typedef enum logic {
        OS_EMPTY = 1'b0,
        OS_FULL  = 1'b1
    } out_state_e;

    // The ALU result is meaningless for a zero divisor, so the front end overrides it.
    function automatic logic is_div_zero(input alu_cmd_t cmd);
        return (cmd.sel == OP_DIV) && (cmd.b == '0);
    endfunction

endpackage

// File: rtl/alu_cmd_queue_if.sv
// Command, ALU and result signals of alu_cmd_queue. Handshakes: a transfer happens
// on a rising edge where valid && ready; valid holds its payload until taken.
interface alu_cmd_queue_if #(parameter int DEPTH = 4);

    logic                       in_valid;
    logic                       in_ready;
    logic [alu_pkg::OP_W-1:0]   in_sel;
    logic [alu_pkg::OPND_W-1:0] in_a;
    logic [alu_pkg::OPND_W-1:0] in_b;

    logic [alu_pkg::OP_W-1:0]   alu_sel;
    logic [alu_pkg::OPND_W-1:0] alu_a;
    logic [alu_pkg::OPND_W-1:0] alu_b;
    logic [alu_pkg::RES_W-1:0]  alu_result;

    logic                       out_valid;
    logic                       out_ready;
    logic [alu_pkg::RES_W-1:0]  out_result;
    logic                       out_dz;
    logic [alu_pkg::OP_W-1:0]   out_sel;

    logic [$clog2(DEPTH):0]     level;

    modport slave (
        input  in_valid, in_sel, in_a, in_b, alu_result, out_ready,
        output in_ready, alu_sel, alu_a, alu_b, out_valid, out_result, out_dz,
               out_sel, level
    );

    modport master (
        output in_valid, in_sel, in_a, in_b, alu_result, out_ready,
        input  in_ready, alu_sel, alu_a, alu_b, out_valid, out_result, out_dz,
               out_sel, level
    );

endinterface

// File: rtl/alu_cmd_queue_fifo.sv
// Synchronous command FIFO; head reads as zero while empty so the ALU sees idle operands.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CMD_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/alu_cmd_queue.sv
// ALU command front end: buffers commands, drives the external ALU from the FIFO head
// and registers one result (with divide-by-zero flag) behind a valid/ready output.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_cmd_queue_if.slave    bus,
    output out_state_e        state_o
);

    localparam int LW = $clog2(DEPTH) + 1;

    alu_cmd_t         in_cmd;
    alu_cmd_t         head;
    logic [CMD_W-1:0] head_raw;
    logic [LW-1:0]    fifo_level;
    logic             fifo_full, fifo_empty;
    logic             push, issue;

    out_state_e       state_q, state_d;
    logic             out_valid;
    logic [RES_W-1:0] out_result_q, result_d;
    logic             out_dz_q, dz_d;
    logic [OP_W-1:0]  out_sel_q;

    assign in_cmd = '{sel: bus.in_sel, a: bus.in_a, b: bus.in_b};

    // in_ready comes only from registered occupancy: a full FIFO never accepts,
    // even when the head is being issued in the same cycle.
    assign bus.in_ready = !fifo_full;
    assign push         = bus.in_valid && !fifo_full;
    assign issue        = !fifo_empty && (!out_valid || bus.out_ready);

    alu_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (issue),
        .wdata_i (in_cmd),
        .head_o  (head_raw),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head        = alu_cmd_t'(head_raw);
    assign bus.alu_sel = head.sel;
    assign bus.alu_a   = head.a;
    assign bus.alu_b   = head.b;
    assign bus.level   = fifo_level;

    always_comb begin
        result_d = bus.alu_result;
        dz_d     = 1'b0;
        if (is_div_zero(head)) begin
            result_d = '0;
            dz_d     = 1'b1;
        end
    end

    // Output register occupancy FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= OS_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OS_EMPTY: if (issue) state_d = OS_FULL;
            OS_FULL:  if (!issue && bus.out_ready) state_d = OS_EMPTY;
            default:  state_d = OS_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == OS_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result_q <= '0;
            out_dz_q     <= 1'b0;
            out_sel_q    <= '0;
        end else if (issue) begin
            out_result_q <= result_d;
            out_dz_q     <= dz_d;
            out_sel_q    <= head.sel;
        end
    end

    assign bus.out_valid  = out_valid;
    assign bus.out_result = out_result_q;
    assign bus.out_dz     = out_dz_q;
    assign bus.out_sel    = out_sel_q;
    assign state_o        = state_q;

endmodule

// File: doc/alu_cmd_queue.md
# alu_cmd_queue

Operand/command front end for the team's combinational 8-bit ALU. Accepts ALU commands (opcode, A, B) over a valid/ready handshake and buffers them in a small FIFO. Issues one command per cycle to the ALU and registers the 16-bit result with a divide-by-zero flag behind a second valid/ready handshake. The ALU is instantiated outside this block, which drives its sel/A/B inputs and samples its result.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  command present
- in_ready  out  1  command accepted when in_valid && in_ready at clk edge
- in_sel  in  4  ALU opcode (0000 add … 1111 equal)
- in_a  in  8  operand A
- in_b  in  8  operand B
- alu_sel  out  4  to ALU sel
- alu_a  out  8  to ALU A
- alu_b  out  8  to ALU B
- alu_result  in  16  from ALU (combinational from alu_*)
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer takes result when out_valid && out_ready at clk edge
- out_result  out  16  registered result
- out_dz  out  1  result was divide (0011) with B==0
- out_sel  out  4  opcode that produced out_result
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

## Operation
- FIFO: push = in_valid && in_ready; in_ready = !full, from registered state only. No write-through when full, even if a pop happens the same cycle.
- alu_sel/alu_a/alu_b always show the FIFO head. When the FIFO is empty they are 0.
- Issue (pop) = !empty && (!out_valid || out_ready). On issue:
  - capture out_result, out_sel and out_dz.
  - out_valid <= 1.
- If there is no issue and out_valid && out_ready, then out_valid <= 0.
- Divide by zero: head sel==4'b0011 and B==8'h00 gives out_result <= 16'h0000 and out_dz <= 1. The ALU output is ignored in this case.
- Every other opcode gives out_result <= alu_result and out_dz <= 0.
- Output register states:
  - EMPTY → FULL on issue.
  - FULL stays FULL on issue with out_ready, or while out_ready is low.
  - FULL → EMPTY on out_ready with no issue.
- Simultaneous push and pop, FIFO not empty and not full: level unchanged, pointers both advance.
- Simultaneous push and pop with the FIFO empty cannot occur, because pop requires !empty. The pushed entry is issued next cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. full/empty are derived from level.
- Commands complete strictly in order. No command is dropped or duplicated.
- Reset, asynchronous and at any time, including mid-stream:
  - level=0, pointers=0.
  - out_valid=0, out_result=0, out_dz=0, out_sel=0.
  - in_ready=1 after reset deasserts, alu_*=0.
  - All queued commands are discarded.

## Timing
- Latency: command accepted at edge E0, with FIFO empty and output EMPTY. It is on alu_* after E0, captured at E1, and out_valid=1 after E1.
- Throughput: 1 result/cycle while out_ready=1.
- Maximum held commands = DEPTH in the FIFO + 1 in the output register.
- Combinational paths:
  - FIFO head → ALU → out_result D-input: one ALU delay per cycle.
  - out_ready → pop.
  - There is no path from in_valid to in_ready, and none from out_ready to out_valid.

## Structure
- Package alu_pkg:
  - 4-bit opcode localparams (OP_ADD=0000 … OP_EQ=1111), with OP_DIV used for the zero check.
  - Operand width 8 and result width 16.
- Sub-module alu_cmd_fifo (parameter DEPTH): sync FIFO of {sel,a,b}, 20 bits. Has push/pop/head/level/full/empty and async active-high reset.
- The top level holds the issue logic and the output register. The bench connects the team ALU to the alu_* ports.

## Test plan
- Single add, idle queue: sel=0000, A=200, B=100 accepted at E0 → out_valid after E1, out_result=16'd300, out_dz=0, out_sel=0000.
- Divide by zero: sel=0011, A=9, B=0 → out_result=16'h0000, out_dz=1. A following sel=0011, A=9, B=2 → 16'd4, out_dz=0.
- Backpressure, DEPTH=4, out_ready=0:
  - 5 commands accepted, in_ready=0 on the 6th cycle, level=4.
  - Raise out_ready → results stream 1/cycle in order.
  - in_ready returns to 1 one cycle after the first pop.
- Streaming with push and pop together:
  - Continuous in_valid and out_ready, 20 mixed ops: sub 3−5 → 16'hFFFE, mul 255×255 → 16'hFE01, cmp 1110 with A=5, B=3 → 16'd1.
  - level never exceeds 1, and there is no bubble after the first result.
- Pointer wrap: 3×DEPTH+1 commands with random out_ready → in-order results matching a reference model, no loss or duplicate.
- Reset mid-operation:
  - Assert rst asynchronously (between edges) with level=3 and out_valid=1.
  - Outputs go to 0 immediately, and level=0.
  - After release, a new add 1+1 returns 16'd2 as the first result.
